room_draw_engine: RTL and testbench
===================================

Name: room_draw_engine

Overview:
- VGA-side responder to the home-simulation control path.
- Takes one of the one-hot room draw enables (enable0..enable4) or the clear request (clearinitsignal).
- Scans the matching pixel region one pixel per cycle, with colours taken from the room's stored light/door status.
- Pulses countDone for one cycle when the scan completes, which lets the control path advance to DONE_DRAW or DONE_CLEAR.

Parameters:
- ROOM_W, 32, room tile width in pixels
- ROOM_H, 24, room tile height in pixels
- ROOM_Y0, 48, top row of the room strip; room i origin is x = ROOM_W*i, y = ROOM_Y0
- SCREEN_W, 160, screen width for clear
- SCREEN_H, 120, screen height for clear
- DOOR_X0, 12, first door column inside the tile, on the bottom row
- DOOR_LEN, 8, door width in pixels

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- room_en  in  5  one-hot draw request; bit i = enable_i from the control path; level-held until countDone
- clear_req  in  1  full-screen clear request; level-held
- light_on  in  5  per-room light status; 1 = on
- door_open  in  5  per-room door status; 1 = open
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  RGB pixel colour
- plot  out  1  pixel write strobe to the VGA adapter
- countDone  out  1  one-cycle completion pulse
- busy  out  1  high in SCAN_ROOM, SCAN_CLEAR or DONE
- err_multi  out  1  one-cycle pulse when room_en has more than one bit set at capture

Behaviour:
- Reset values: all outputs 0; state IDLE; counters 0.
- State IDLE:
  - clear_req=1 -> SCAN_CLEAR. Clear has priority over room_en.
  - Else room_en!=0 -> SCAN_ROOM.
  - On capture, latch: room index = lowest set bit; light_on[idx]; door_open[idx].
  - Pulse err_multi if popcount(room_en) > 1.
- State SCAN_ROOM:
  - Row-major scan, column counter cx over 0..ROOM_W-1, row counter cy over 0..ROOM_H-1.
  - Registered outputs: x = ROOM_W*idx + cx, y = ROOM_Y0 + cy, plot = 1.
  - First plot is one cycle after the capture cycle; one pixel per cycle; ROOM_W*ROOM_H = 768 plot cycles.
  - Colour rules, first match wins:
    - Door pixel: cy = ROOM_H-1 and DOOR_X0 <= cx < DOOR_X0+DOOR_LEN. Colour 3'b010 (green) if door open, else 3'b100 (red).
    - Border pixel: cx = 0, cx = ROOM_W-1, cy = 0 or cy = ROOM_H-1. Colour 3'b111.
    - Interior pixel: 3'b110 if light on, else 3'b001.
  - After the last pixel (cx = ROOM_W-1, cy = ROOM_H-1) -> DONE.
- State SCAN_CLEAR:
  - Same scan over SCREEN_W x SCREEN_H from (0,0).
  - colour = 3'b000, plot = 1; 19200 plot cycles.
  - After the last pixel -> DONE.
- State DONE:
  - countDone = 1 for exactly one cycle; plot = 0.
  - Next state WAIT_RELEASE.
- State WAIT_RELEASE:
  - Stays until room_en = 0 and clear_req = 0, then -> IDLE.
  - This prevents retriggering: the control path drops its enable the cycle after countDone.
- Abort rules:
  - clear_req rises during SCAN_ROOM -> next cycle enters SCAN_CLEAR at (0,0). No countDone for the aborted room.
  - room_en drops to 0 mid SCAN_ROOM without clear -> abort to IDLE; plot = 0 next cycle; no countDone.
  - room_en changes to a different room mid-scan -> ignored; the latched idx is used.
  - clear_req drop mid SCAN_CLEAR -> the clear completes anyway; the control path never drops it early.
  - reset mid-scan -> IDLE next cycle; all outputs 0.
- Width rules:
  - x is computed in 8 bits; the maximum is 159, so there is no overflow.
  - cx and cy counters are sized $clog2 of the screen dimensions.
  - The room-index multiply is a shift by 5 (ROOM_W = 32) and is implemented as a shift.

Decomposition:
- Package home_sim_pkg:
  - state enum (IDLE, SCAN_ROOM, SCAN_CLEAR, DONE, WAIT_RELEASE)
  - colour constants: COL_BLACK, COL_WHITE, COL_YELLOW, COL_BLUE_DARK, COL_RED, COL_GREEN
  - screen/room geometry constants, shared with the control path
- Sub-module xy_scan_counter:
  - inputs: width and height limits, start, enable
  - outputs: cx, cy, last
  - reused for both the room scan and the clear scan

Test Plan:
- room_en=5'b00001, light_on[0]=1, door_open[0]=0:
  - 768 plots, x over 0..31, y over 48..71
  - pixel (15,60) = 3'b110; (0,48) = 3'b111; (14,71) = 3'b100
  - countDone high exactly one cycle, at cycle 769 after capture
- room_en=5'b10000, light off, door open:
  - first plot x=128, y=48
  - (140,71) = 3'b010; interior (140,60) = 3'b001
  - last plot x=159, y=71
- clear_req=1: 19200 plots, all colour 000; last (159,119); then a single countDone.
- clear_req asserted at plot 100 of a room 2 draw:
  - next plot is (0,0) colour 000
  - exactly one countDone, after the full clear
- room_en=5'b00110:
  - err_multi pulses at capture; room 1 is drawn (first x=32)
  - room_en held high after countDone -> no second scan until room_en returns to 0
- reset at plot 300 -> next cycle plot=0, busy=0, x=y=0; a new request then starts cleanly.

Source files
------------

// File: rtl/home_sim_pkg.sv
// Shared types, colours and screen/room geometry for the home-simulation VGA path.
// The control path imports the same constants so both sides agree on the layout.
package home_sim_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_ROOM,
        SCAN_CLEAR,
        DONE,
        WAIT_RELEASE
    } state_t;

    localparam logic [2:0] COL_BLACK     = 3'b000;
    localparam logic [2:0] COL_WHITE     = 3'b111;
    localparam logic [2:0] COL_YELLOW    = 3'b110;
    localparam logic [2:0] COL_BLUE_DARK = 3'b001;
    localparam logic [2:0] COL_RED       = 3'b100;
    localparam logic [2:0] COL_GREEN     = 3'b010;

    localparam int NUM_ROOMS = 5;
    localparam int ROOM_W    = 32;
    localparam int ROOM_H    = 24;
    localparam int ROOM_Y0   = 48;
    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int DOOR_X0   = 12;
    localparam int DOOR_LEN  = 8;

    localparam int X_W        = $clog2(SCREEN_W);
    localparam int Y_W        = $clog2(SCREEN_H);
    localparam int IDX_W      = $clog2(NUM_ROOMS);
    localparam int ROOM_SHIFT = $clog2(ROOM_W);

    // Lowest set bit wins when the control path raises more than one enable.
    function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_ROOMS-1:0] v);
        lowest_set = '0;
        for (int i = NUM_ROOMS - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = IDX_W'(i);
        end
    endfunction

    function automatic logic multi_hot(input logic [NUM_ROOMS-1:0] v);
        return (v & (v - NUM_ROOMS'(1))) != '0;
    endfunction

endpackage

// File: rtl/xy_scan_counter.sv
// Row-major raster counter; start clears to (0,0), enable advances one pixel.
// last flags the final pixel of the width x height window currently selected.
module xy_scan_counter
    import home_sim_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic [X_W-1:0] width,
    input  logic [Y_W-1:0] height,
    input  logic           start,
    input  logic           enable,
    output logic [X_W-1:0] cx,
    output logic [Y_W-1:0] cy,
    output logic           last
);

    logic x_end;

    assign x_end = (cx == width - X_W'(1));
    assign last  = x_end && (cy == height - Y_W'(1));

    always_ff @(posedge clock) begin
        if (reset || start) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (x_end) begin
                cx <= '0;
                cy <= last ? '0 : cy + Y_W'(1);
            end else begin
                cx <= cx + X_W'(1);
            end
        end
    end

endmodule

// File: rtl/room_draw_engine.sv
// Draws one room tile (or clears the screen) one pixel per cycle for the VGA adapter,
// then pulses countDone once and waits for the control path to drop its request.
module room_draw_engine
    import home_sim_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NUM_ROOMS-1:0] room_en,
    input  logic                 clear_req,
    input  logic [NUM_ROOMS-1:0] light_on,
    input  logic [NUM_ROOMS-1:0] door_open,
    output logic [X_W-1:0]       x,
    output logic [Y_W-1:0]       y,
    output logic [2:0]           colour,
    output logic                 plot,
    output logic                 countDone,
    output logic                 busy,
    output logic                 err_multi,
    output state_t               state
);

    state_t           state_next;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] sel;
    logic             light_q;
    logic             door_q;
    logic             capture;
    logic             start;
    logic             enable;
    logic [X_W-1:0]   cx;
    logic [Y_W-1:0]   cy;
    logic [X_W-1:0]   lim_w;
    logic [Y_W-1:0]   lim_h;
    logic             last;
    logic             door_pix;
    logic             border_pix;

    assign sel   = lowest_set(room_en);
    assign lim_w = (state == SCAN_CLEAR) ? X_W'(SCREEN_W) : X_W'(ROOM_W);
    assign lim_h = (state == SCAN_CLEAR) ? Y_W'(SCREEN_H) : Y_W'(ROOM_H);

    xy_scan_counter u_scan (
        .clock  (clock),
        .reset  (reset),
        .width  (lim_w),
        .height (lim_h),
        .start  (start),
        .enable (enable),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            light_q   <= 1'b0;
            door_q    <= 1'b0;
            err_multi <= 1'b0;
        end else begin
            state     <= state_next;
            err_multi <= capture && multi_hot(room_en);
            if (capture) begin
                idx     <= sel;
                light_q <= light_on[sel];
                door_q  <= door_open[sel];
            end
        end
    end

    // Clear outranks everything, including an in-progress room; a dropped enable aborts silently.
    always_comb begin
        state_next = state;
        start      = 1'b0;
        enable     = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                start = 1'b1;
                if (clear_req) begin
                    state_next = SCAN_CLEAR;
                end else if (room_en != '0) begin
                    state_next = SCAN_ROOM;
                    capture    = 1'b1;
                end
            end
            SCAN_ROOM: begin
                if (clear_req) begin
                    state_next = SCAN_CLEAR;
                    start      = 1'b1;
                end else if (room_en == '0) begin
                    state_next = IDLE;
                end else if (last) begin
                    state_next = DONE;
                end else begin
                    enable = 1'b1;
                end
            end
            SCAN_CLEAR: begin
                if (last) state_next = DONE;
                else      enable     = 1'b1;
            end
            DONE: state_next = WAIT_RELEASE;
            WAIT_RELEASE: begin
                if (room_en == '0 && !clear_req) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign door_pix   = (cy == Y_W'(ROOM_H - 1)) && (cx >= X_W'(DOOR_X0))
                        && (cx < X_W'(DOOR_X0 + DOOR_LEN));
    assign border_pix = (cx == '0) || (cx == X_W'(ROOM_W - 1))
                        || (cy == '0) || (cy == Y_W'(ROOM_H - 1));

    always_comb begin
        x      = '0;
        y      = '0;
        colour = COL_BLACK;
        plot   = 1'b0;
        case (state)
            SCAN_ROOM: begin
                x    = (X_W'(idx) << ROOM_SHIFT) + cx;
                y    = Y_W'(ROOM_Y0) + cy;
                plot = 1'b1;
                if (door_pix)        colour = door_q ? COL_GREEN : COL_RED;
                else if (border_pix) colour = COL_WHITE;
                else                 colour = light_q ? COL_YELLOW : COL_BLUE_DARK;
            end
            SCAN_CLEAR: begin
                x    = cx;
                y    = cy;
                plot = 1'b1;
            end
            default: ;
        endcase
    end

    assign countDone = (state == DONE);
    assign busy      = (state == SCAN_ROOM) || (state == SCAN_CLEAR) || (state == DONE);

endmodule

// File: tb/tb_room_draw_engine.sv
// Directed and randomized room draws / screen clears checked pixel by pixel
// against a raster model built from the geometry and colour rules.
module tb_room_draw_engine;
    import home_sim_pkg::*;

    logic       clock = 1'b0;
    logic       reset;
    logic [4:0] room_en;
    logic       clear_req;
    logic [4:0] light_on;
    logic [4:0] door_open;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
    logic       countDone;
    logic       busy;
    logic       err_multi;
    state_t     state;

    int         n_vec  = 0;
    int         n_miss = 0;
    logic       exp_err;
    logic [17:0] exp_q[$];

    always #5 clock = ~clock;

    room_draw_engine dut (
        .clock     (clock),
        .reset     (reset),
        .room_en   (room_en),
        .clear_req (clear_req),
        .light_on  (light_on),
        .door_open (door_open),
        .x         (x),
        .y         (y),
        .colour    (colour),
        .plot      (plot),
        .countDone (countDone),
        .busy      (busy),
        .err_multi (err_multi),
        .state     (state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    function automatic logic [2:0] ref_colour(int cx, int cy, bit light, bit door);
        if (cy == 23 && cx >= 12 && cx < 20) return door ? 3'b010 : 3'b100;
        if (cx == 0 || cx == 31 || cy == 0 || cy == 23) return 3'b111;
        return light ? 3'b110 : 3'b001;
    endfunction

    function automatic int lowest(logic [4:0] en);
        int r = 0;
        for (int i = 4; i >= 0; i--) if (en[i]) r = i;
        return r;
    endfunction

    task automatic load_room(input int idx, input bit light, input bit door);
        exp_q.delete();
        for (int cy = 0; cy < 24; cy++)
            for (int cx = 0; cx < 32; cx++)
                exp_q.push_back({8'(32 * idx + cx), 7'(48 + cy), ref_colour(cx, cy, light, door)});
    endtask

    task automatic load_clear();
        exp_q.delete();
        for (int cy = 0; cy < 120; cy++)
            for (int cx = 0; cx < 160; cx++)
                exp_q.push_back({8'(cx), 7'(cy), 3'b000});
    endtask

    task automatic start_room(input logic [4:0] en);
        int idx;
        idx     = lowest(en);
        room_en = en;
        load_room(idx, light_on[idx], door_open[idx]);
        exp_err = ($countones(en) > 1);
    endtask

    // Each pixel compares {plot, countDone, busy, err_multi, x, y, colour}.
    task automatic expect_pixels(input int n, input string tag);
        logic [17:0] e;
        repeat (n) begin
            e = exp_q.pop_front();
            tick();
            check(tag, {10'd0, plot, countDone, busy, err_multi, x, y, colour},
                  {10'd0, 3'b101, exp_err, e});
            exp_err = 1'b0;
        end
    endtask

    task automatic finish_done(input int hold);
        tick();
        check("countdone", {28'd0, plot, countDone, busy, err_multi}, 32'b0110);
        repeat (hold) begin
            tick();
            check("hold_no_retrigger", {29'd0, plot, countDone, busy}, 32'd0);
        end
        room_en   = '0;
        clear_req = 1'b0;
        tick();
        tick();
        check("release_out", {14'd0, plot, countDone, busy, x, y, colour}, 32'd0);
        check("release_state", 32'(state), 32'(IDLE));
    endtask

    initial begin
        logic [4:0] en;
        logic [4:0] new_en;
        int         mode;
        int         k;

        reset     = 1'b1;
        room_en   = '0;
        clear_req = 1'b0;
        light_on  = '0;
        door_open = '0;
        exp_err   = 1'b0;
        tick();
        tick();
        check("reset_out", {13'd0, plot, countDone, busy, err_multi, x, y, colour}, 32'd0);
        check("reset_state", 32'(state), 32'(IDLE));
        reset = 1'b0;
        tick();
        check("idle_out", {28'd0, plot, countDone, busy, err_multi}, 32'd0);

        // Room 0, light on, door closed.
        light_on  = 5'($urandom_range(0, 31)) | 5'b00001;
        door_open = 5'($urandom_range(0, 31)) & 5'b11110;
        start_room(5'b00001);
        expect_pixels(768, "room0");
        finish_done(0);

        // Room 4, light off, door open.
        light_on  = 5'($urandom_range(0, 31)) & 5'b01111;
        door_open = 5'($urandom_range(0, 31)) | 5'b10000;
        start_room(5'b10000);
        expect_pixels(768, "room4");
        finish_done(0);

        // Full clear; the request drops part-way and the clear still completes.
        clear_req = 1'b1;
        exp_err   = 1'b0;
        load_clear();
        expect_pixels(5000, "clear");
        clear_req = 1'b0;
        expect_pixels(14200, "clear_after_drop");
        finish_done(0);

        // Clear arrives at plot 100 of a room 2 draw.
        light_on  = 5'($urandom_range(0, 31));
        door_open = 5'($urandom_range(0, 31));
        start_room(5'b00100);
        expect_pixels(100, "room2_pre_abort");
        clear_req = 1'b1;
        load_clear();
        expect_pixels(19200, "abort_clear");
        finish_done(0);

        // Two enables: lowest wins, err_multi flags it, holding the enable must not retrigger.
        start_room(5'b00110);
        expect_pixels(768, "multi_room1");
        finish_done(5);

        // Reset at plot 300, then a fresh request.
        start_room(5'b01000);
        expect_pixels(300, "room3_pre_reset");
        reset   = 1'b1;
        room_en = '0;
        tick();
        check("reset_mid_out", {13'd0, plot, countDone, busy, err_multi, x, y, colour}, 32'd0);
        check("reset_mid_state", 32'(state), 32'(IDLE));
        reset = 1'b0;
        tick();
        light_on  = 5'($urandom_range(0, 31));
        door_open = 5'($urandom_range(0, 31));
        start_room(5'b01000);
        expect_pixels(768, "room3_after_reset");
        finish_done(0);

        // Randomized draws: complete, enable switched mid-scan, or enable dropped mid-scan.
        for (int it = 0; it < 8; it++) begin
            en        = 5'($urandom_range(1, 31));
            light_on  = 5'($urandom_range(0, 31));
            door_open = 5'($urandom_range(0, 31));
            mode      = $urandom_range(0, 2);
            k         = $urandom_range(1, 767);
            start_room(en);
            if (mode == 0) begin
                expect_pixels(768, "rand_full");
                finish_done($urandom_range(0, 3));
            end else if (mode == 1) begin
                expect_pixels(k, "rand_pre_switch");
                do new_en = 5'($urandom_range(1, 31)); while (new_en == en);
                room_en = new_en;
                expect_pixels(768 - k, "rand_post_switch");
                finish_done(0);
            end else begin
                expect_pixels(k, "rand_pre_drop");
                room_en = '0;
                tick();
                check("drop_out", {29'd0, plot, countDone, busy}, 32'd0);
                check("drop_state", 32'(state), 32'(IDLE));
                exp_q.delete();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
